// File: rtl/fpu_wb_arbiter.sv
// ============================================================================
// fpu_wb_arbiter
//
// Merges sign-injection results (fsgnj/fsgnjn/fsgnjx/fabs/fneg) and
// long-latency FPU results onto the single FP register-file write port, one
// write per cycle.
//
//   - Long-latency results have no ready handshake and always win the port.
//   - Sign-unit results that cannot be written immediately are held in a
//     small in-order FIFO. s_ready back-pressures the sign unit when the FIFO
//     is full, during flush and while in reset.
//   - flush discards every queued sign result and refuses the incoming one.
//   - wb_en / wb_rd / wb_data are registered. wb_rd / wb_data keep their last
//     value on idle cycles.
//
// Build option:
//   FPU_WB_BYPASS_EN  when defined, an accepted sign result goes straight to
//                     the write port if no long-latency result is present
//                     and the FIFO is empty (1-cycle latency). When undefined,
//                     every sign result is pushed and later popped (minimum
//                     2-cycle latency).
//
// Reset: rstn, synchronous, active-low.
// ============================================================================
module fpu_wb_arbiter #(
    parameter int DEPTH = 4,   // sign-result FIFO entries, power of two, >= 2
    parameter int RW    = 5,   // register index width
    parameter int DW    = 32   // data width
) (
    input  logic                     clk,
    input  logic                     rstn,

    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [RW-1:0]            s_rd,
    input  logic [DW-1:0]            s_data,

    input  logic                     l_valid,
    input  logic [RW-1:0]            l_rd,
    input  logic [DW-1:0]            l_data,

    input  logic                     flush,

    output logic                     wb_en,
    output logic [RW-1:0]            wb_rd,
    output logic [DW-1:0]            wb_data,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int PW = $clog2(DEPTH);   // pointer width, wraps modulo DEPTH
    localparam int CW = PW + 1;          // count width, holds 0..DEPTH

    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [PW-1:0] PTR_ONE    = PW'(1);
    localparam logic [CW-1:0] COUNT_ONE  = CW'(1);

    // One queued sign-unit result.
    typedef struct packed {
        logic [RW-1:0] rd;
        logic [DW-1:0] data;
    } entry_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    entry_t            mem_q [DEPTH];

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q,  count_d;

    logic              wb_en_q,   wb_en_d;
    logic [RW-1:0]     wb_rd_q,   wb_rd_d;
    logic [DW-1:0]     wb_data_q, wb_data_d;

    // ------------------------------------------------------------------------
    // Handshake and FIFO status
    // ------------------------------------------------------------------------
    logic              fifo_empty;
    logic              accept;
    logic              pop;
    logic              push;
    logic              bypass_take;
    entry_t            head;
    entry_t            s_entry;

    assign fifo_empty = (count_q == '0);
    assign head       = mem_q[rd_ptr_q];
    assign s_entry    = '{rd: s_rd, data: s_data};

    // Ready is derived from the registered count only, so a pop from a full
    // FIFO frees its slot to the sign unit one cycle later.
    assign s_ready = rstn & ~flush & (count_q < FULL_COUNT);
    assign accept  = s_valid & s_ready;

    // An accepted result is queued unless it went straight to the port.
    assign push = accept & ~bypass_take;

    // Write-port source selection: long-latency, then FIFO head, then bypass.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned, which would infer a latch.
        wb_en_d     = 1'b0;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        pop         = 1'b0;
        bypass_take = 1'b0;

        if (l_valid) begin
            wb_en_d   = 1'b1;
            wb_rd_d   = l_rd;
            wb_data_d = l_data;
        end else if (!fifo_empty && !flush) begin
            // flush cancels the pop; the head entry is discarded instead.
            wb_en_d   = 1'b1;
            wb_rd_d   = head.rd;
            wb_data_d = head.data;
            pop       = 1'b1;
`ifdef FPU_WB_BYPASS_EN
        end else if (accept) begin
            wb_en_d     = 1'b1;
            wb_rd_d     = s_rd;
            wb_data_d   = s_data;
            bypass_take = 1'b1;
`endif
        end
    end

    // Pointer and occupancy update; flush empties the FIFO in one cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + COUNT_ONE;
                2'b01:   count_d = count_q - COUNT_ONE;
                default: count_d = count_q;   // idle, or push and pop together
            endcase
        end
    end

    // Control and write-port registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of every other flop.
        if (!rstn) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            wb_en_q   <= 1'b0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            wb_en_q   <= wb_en_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
        end
    end

    // FIFO storage write; push is already low during reset and flush.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset. An entry is only
        // read when count/pointers say it is valid, so clearing the array
        // would add reset fan-out without changing behaviour.
        if (push) begin
            mem_q[wr_ptr_q] <= s_entry;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign wb_en      = wb_en_q;
    assign wb_rd      = wb_rd_q;
    assign wb_data    = wb_data_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_fpu_wb_arbiter.sv
// ============================================================================
// tb_fpu_wb_arbiter
//
// Directed scenarios plus randomized traffic for fpu_wb_arbiter. The
// reference model is a queue of pending sign results and a record of the
// last write, advanced once per clock from the arbitration rules. Build with
// +define+FPU_WB_BYPASS_EN on both files to exercise the bypass variant.
// ============================================================================
module tb_fpu_wb_arbiter;

    localparam int DEPTH = 4;
    localparam int RW    = 5;
    localparam int DW    = 32;

`ifdef FPU_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                   clk;
    logic                   rstn;
    logic                   s_valid;
    logic                   s_ready;
    logic [RW-1:0]          s_rd;
    logic [DW-1:0]          s_data;
    logic                   l_valid;
    logic [RW-1:0]          l_rd;
    logic [DW-1:0]          l_data;
    logic                   flush;
    logic                   wb_en;
    logic [RW-1:0]          wb_rd;
    logic [DW-1:0]          wb_data;
    logic [$clog2(DEPTH):0] fifo_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: pending sign results in acceptance order, last write.
    logic [RW+DW-1:0] m_q[$];
    logic             m_en;
    logic [RW-1:0]    m_rd;
    logic [DW-1:0]    m_data;

    fpu_wb_arbiter #(.DEPTH(DEPTH), .RW(RW), .DW(DW)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_rd       (s_rd),
        .s_data     (s_data),
        .l_valid    (l_valid),
        .l_rd       (l_rd),
        .l_data     (l_data),
        .flush      (flush),
        .wb_en      (wb_en),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .fifo_count (fifo_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic bit model_ready();
        return rstn && !flush && (m_q.size() < DEPTH);
    endfunction

    // Advance model from the current inputs, then move the DUT one clock.
    // Returns at the following negedge, where outputs are sampled.
    task automatic cycle();
        bit               acc;
        logic [RW+DW-1:0] e;
        acc = s_valid && model_ready();
        if (!rstn) begin
            m_q.delete();
            m_en   = 1'b0;
            m_rd   = '0;
            m_data = '0;
        end else begin
            if (l_valid) begin
                m_en   = 1'b1;
                m_rd   = l_rd;
                m_data = l_data;
            end else if (!flush && m_q.size() > 0) begin
                e      = m_q.pop_front();
                m_en   = 1'b1;
                m_rd   = e[RW+DW-1:DW];
                m_data = e[DW-1:0];
            end else if (BYP && acc) begin
                m_en   = 1'b1;
                m_rd   = s_rd;
                m_data = s_data;
                acc    = 1'b0;
            end else begin
                m_en   = 1'b0;
            end
            if (flush) m_q.delete();
            if (acc) m_q.push_back({s_rd, s_data});
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_idle();
        s_valid = 1'b0;
        l_valid = 1'b0;
        flush   = 1'b0;
        s_rd    = '0;
        s_data  = '0;
        l_rd    = '0;
        l_data  = '0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        set_idle();
        cycle();
        cycle();
        n_checks++; if (wb_en !== 1'b0) begin n_fail++; $display("FAIL reset_wb_en: got %b want 0", wb_en); end
        n_checks++; if (wb_rd !== '0) begin n_fail++; $display("FAIL reset_wb_rd: got %h want 0", wb_rd); end
        n_checks++; if (wb_data !== '0) begin n_fail++; $display("FAIL reset_wb_data: got %h want 0", wb_data); end
        n_checks++; if (fifo_count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        s_valid = 1'b1;
        #1;
        n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL reset_s_ready: got %b want 0", s_ready); end
        s_valid = 1'b0;
        rstn = 1'b1;
        #1;
        n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_s_ready: got %b want 1", s_ready); end
    endtask

    // Single sign result: 1-cycle latency with bypass, 2 cycles without.
    task automatic test_single();
        int lat;
        lat = BYP ? 1 : 2;
        s_valid = 1'b1;
        s_rd    = 5'd3;
        s_data  = 32'h3F80_0000;
        for (int c = 1; c <= lat; c++) begin
            cycle();
            s_valid = 1'b0;
            n_checks++; if (wb_en !== (c == lat)) begin n_fail++; $display("FAIL single_lat_c%0d: wb_en got %b want %b", c, wb_en, (c == lat)); end
        end
        n_checks++; if (wb_rd !== 5'd3) begin n_fail++; $display("FAIL single_rd: got %0d want 3", wb_rd); end
        n_checks++; if (wb_data !== 32'h3F80_0000) begin n_fail++; $display("FAIL single_data: got %h want 3f800000", wb_data); end
        n_checks++; if (fifo_count !== '0) begin n_fail++; $display("FAIL single_count: got %0d want 0", fifo_count); end
        cycle();
        n_checks++; if (wb_en !== 1'b0) begin n_fail++; $display("FAIL single_idle_en: got %b want 0", wb_en); end
        n_checks++; if (wb_rd !== 5'd3 || wb_data !== 32'h3F80_0000) begin n_fail++; $display("FAIL single_hold: got rd=%0d data=%h want rd=3 data=3f800000", wb_rd, wb_data); end
    endtask

    // Same-cycle s and l: l first, s next cycle.
    task automatic test_collision();
        s_valid = 1'b1; s_rd = 5'd1; s_data = 32'hAAAA_0001;
        l_valid = 1'b1; l_rd = 5'd2; l_data = 32'hBBBB_0002;
        cycle();
        set_idle();
        n_checks++; if (wb_en !== 1'b1 || wb_rd !== 5'd2 || wb_data !== 32'hBBBB_0002) begin n_fail++; $display("FAIL collide_l: got en=%b rd=%0d data=%h want en=1 rd=2 data=bbbb0002", wb_en, wb_rd, wb_data); end
        n_checks++; if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL collide_count: got %0d want 1", fifo_count); end
        cycle();
        n_checks++; if (wb_en !== 1'b1 || wb_rd !== 5'd1 || wb_data !== 32'hAAAA_0001) begin n_fail++; $display("FAIL collide_s: got en=%b rd=%0d data=%h want en=1 rd=1 data=aaaa0001", wb_en, wb_rd, wb_data); end
        n_checks++; if (fifo_count !== '0) begin n_fail++; $display("FAIL collide_count2: got %0d want 0", fifo_count); end
        cycle();
    endtask

    // l_valid held 6 cycles: FIFO fills to DEPTH, then drains 1..6 in order.
    task automatic test_backpressure();
        int            k;
        logic [DW-1:0] got[$];
        k = 1;
        for (int c = 0; c < 6; c++) begin
            l_valid = 1'b1; l_rd = 5'd20; l_data = 32'h0000_1000 + DW'(c);
            s_valid = 1'b1; s_rd = RW'(k); s_data = DW'(k);
            #1;
            n_checks++; if (s_ready !== (c < DEPTH)) begin n_fail++; $display("FAIL bp_ready_c%0d: got %b want %b", c, s_ready, (c < DEPTH)); end
            if (s_ready) k++;
            cycle();
            n_checks++; if (wb_en !== 1'b1 || wb_data !== 32'h0000_1000 + DW'(c)) begin n_fail++; $display("FAIL bp_l_c%0d: got en=%b data=%h want en=1 data=%h", c, wb_en, wb_data, 32'h0000_1000 + c); end
        end
        n_checks++; if (k !== DEPTH + 1) begin n_fail++; $display("FAIL bp_accepts: got %0d want %0d", k - 1, DEPTH); end
        l_valid = 1'b0;
        for (int c = 0; c < 20 && got.size() < 6; c++) begin
            s_valid = (k <= 6); s_rd = RW'(k); s_data = DW'(k);
            #1;
            if (s_valid && s_ready) k++;
            cycle();
            if (wb_en) got.push_back(wb_data);
        end
        set_idle();
        n_checks++; if (got.size() != 6) begin n_fail++; $display("FAIL bp_drain_count: got %0d writes want 6", got.size()); end
        foreach (got[i]) begin
            n_checks++; if (got[i] !== DW'(i + 1)) begin n_fail++; $display("FAIL bp_order_%0d: got %h want %h", i, got[i], i + 1); end
        end
    endtask

    // Three queued entries, then flush together with an l result.
    task automatic test_flush();
        l_valid = 1'b1; l_rd = 5'd9; l_data = 32'h0000_0900;
        s_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_rd = RW'(10 + i); s_data = 32'h0000_0500 + DW'(i);
            cycle();
        end
        n_checks++; if (fifo_count !== 3'd3) begin n_fail++; $display("FAIL flush_pre_count: got %0d want 3", fifo_count); end
        flush = 1'b1; l_rd = 5'd7; l_data = 32'h0000_0777; s_data = 32'h0000_05FF;
        #1;
        n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %b want 0", s_ready); end
        cycle();
        set_idle();
        n_checks++; if (wb_en !== 1'b1 || wb_rd !== 5'd7 || wb_data !== 32'h0000_0777) begin n_fail++; $display("FAIL flush_l: got en=%b rd=%0d data=%h want en=1 rd=7 data=777", wb_en, wb_rd, wb_data); end
        n_checks++; if (fifo_count !== '0) begin n_fail++; $display("FAIL flush_count: got %0d want 0", fifo_count); end
        #1;
        n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready_after: got %b want 1", s_ready); end
        for (int c = 0; c < 6; c++) begin
            cycle();
            n_checks++; if (wb_en !== 1'b0) begin n_fail++; $display("FAIL flush_leak_c%0d: got wb_en=%b rd=%0d want 0", c, wb_en, wb_rd); end
        end
    endtask

    // Reset with two queued entries and an active write.
    task automatic test_reset_mid();
        l_valid = 1'b1; l_rd = 5'd4; l_data = 32'h0000_0400;
        s_valid = 1'b1; s_rd = 5'd12; s_data = 32'h0000_0C00;
        cycle();
        s_rd = 5'd13; s_data = 32'h0000_0D00;
        cycle();
        n_checks++; if (fifo_count !== 3'd2 || wb_en !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre: got count=%0d en=%b want count=2 en=1", fifo_count, wb_en); end
        set_idle();
        rstn = 1'b0;
        cycle();
        n_checks++; if (wb_en !== 1'b0 || wb_rd !== '0 || wb_data !== '0) begin n_fail++; $display("FAIL rstmid_wb: got en=%b rd=%0d data=%h want 0/0/0", wb_en, wb_rd, wb_data); end
        n_checks++; if (fifo_count !== '0) begin n_fail++; $display("FAIL rstmid_count: got %0d want 0", fifo_count); end
        rstn = 1'b1;
        for (int c = 0; c < 5; c++) begin
            cycle();
            n_checks++; if (wb_en !== 1'b0) begin n_fail++; $display("FAIL rstmid_leak_c%0d: got wb_en=%b want 0", c, wb_en); end
        end
    endtask

    // 3*DEPTH+1 sign results with alternating l results: pointer wrap.
    task automatic test_wrap();
        int            n_s;
        int            sent;
        logic [DW-1:0] seen[$];
        n_s  = 3 * DEPTH + 1;
        sent = 0;
        for (int c = 0; c < 80 && seen.size() < n_s; c++) begin
            s_valid = (sent < n_s); s_rd = RW'(sent % 30); s_data = 32'hC0DE_0000 + DW'(sent);
            l_valid = ((c % 2) == 1); l_rd = 5'd31; l_data = 32'hF000_0000 + DW'(c);
            #1;
            n_checks++; if (s_ready !== model_ready()) begin n_fail++; $display("FAIL wrap_ready_c%0d: got %b want %b", c, s_ready, model_ready()); end
            if (s_valid && s_ready) sent++;
            cycle();
            n_checks++; if (wb_en !== m_en || wb_rd !== m_rd || wb_data !== m_data || int'(fifo_count) != m_q.size()) begin
                n_fail++; $display("FAIL wrap_c%0d: got en=%b rd=%0d data=%h cnt=%0d want en=%b rd=%0d data=%h cnt=%0d", c, wb_en, wb_rd, wb_data, fifo_count, m_en, m_rd, m_data, m_q.size());
            end
            if (wb_en && wb_rd != 5'd31) seen.push_back(wb_data);
        end
        set_idle();
        n_checks++; if (seen.size() != n_s) begin n_fail++; $display("FAIL wrap_total: got %0d s writes want %0d", seen.size(), n_s); end
        foreach (seen[i]) begin
            n_checks++; if (seen[i] !== 32'hC0DE_0000 + DW'(i)) begin n_fail++; $display("FAIL wrap_order_%0d: got %h want %h", i, seen[i], 32'hC0DE_0000 + i); end
        end
    endtask

    // Random traffic with occasional flush and reset, compared every cycle.
    task automatic test_random();
        for (int c = 0; c < 420; c++) begin
            if (c < 400) begin
                rstn    = ($urandom_range(63) != 0);
                flush   = ($urandom_range(15) == 0);
                s_valid = $urandom_range(1);
                l_valid = ($urandom_range(2) == 0);
            end else begin
                rstn = 1'b1; flush = 1'b0; s_valid = 1'b0; l_valid = 1'b0;
            end
            s_rd = RW'($urandom); s_data = $urandom;
            l_rd = RW'($urandom); l_data = $urandom;
            #1;
            n_checks++; if (s_ready !== model_ready()) begin n_fail++; $display("FAIL rand_ready_c%0d: got %b want %b", c, s_ready, model_ready()); end
            cycle();
            n_checks++; if (wb_en !== m_en || wb_rd !== m_rd || wb_data !== m_data || int'(fifo_count) != m_q.size()) begin
                n_fail++; $display("FAIL rand_c%0d: got en=%b rd=%0d data=%h cnt=%0d want en=%b rd=%0d data=%h cnt=%0d", c, wb_en, wb_rd, wb_data, fifo_count, m_en, m_rd, m_data, m_q.size());
            end
        end
        set_idle();
    endtask

    initial begin
        rstn = 1'b0;
        set_idle();
        @(negedge clk);
        test_reset();
        test_single();
        test_collision();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
